// File: rtl/raster_fifo_arbiter_pkg.sv
// Shared definitions for the raster FIFO arbiter.
// State encoding and default sample width.
package raster_fifo_arbiter_pkg;

  localparam int DAT_WID_DFLT = 24;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/raster_fifo_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter with a 1-bit priority flag.
// Priority passes to the loser after every granted transfer.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic r_prio;

  always_comb begin
    grant = 2'b00;
    if (req[0] && (!req[1] || !r_prio))
      grant = 2'b01;
    else if (req[1])
      grant = 2'b10;
  end

  // r_prio=0 favours A, 1 favours B
  always_ff @(posedge clk) begin
    if (rst)
      r_prio <= 1'b0;
    else if (advance)
      r_prio <= grant[0];
  end

endmodule

// File: rtl/raster_fifo_arbiter.sv
// Arbitrates two writers into a shared FIFO and streams it out.
// Supports a level flush that drains and discards FIFO contents.
module raster_fifo_arbiter
  import raster_fifo_arbiter_pkg::*;
#(
  parameter int DAT_WID = DAT_WID_DFLT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_a,
  input  logic signed [DAT_WID-1:0] dat_a,
  output logic                      ack_a,
  input  logic                      req_b,
  input  logic signed [DAT_WID-1:0] dat_b,
  output logic                      ack_b,
  output logic                      fifo_write_enable,
  output logic        [DAT_WID-1:0] fifo_write_dat,
  input  logic                      fifo_full,
  output logic                      fifo_read_enable,
  input  logic        [DAT_WID-1:0] fifo_read_dat,
  input  logic                      fifo_empty,
  output logic                      out_valid,
  output logic        [DAT_WID-1:0] out_dat,
  input  logic                      out_ready,
  input  logic                      flush,
  output logic                      flush_done
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_pend;
  logic                 r_out_valid;
  logic [DAT_WID-1:0]   r_out_dat;
  logic                 w_wr_ok;
  logic [1:0]           w_req;
  logic [1:0]           w_grant;

  assign w_wr_ok = !rst && !fifo_full && (r_state == ST_RUN);
  assign w_req   = {req_b & w_wr_ok, req_a & w_wr_ok};

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (w_req),
    .advance (fifo_write_enable),
    .grant   (w_grant)
  );

  assign ack_a             = w_grant[0];
  assign ack_b             = w_grant[1];
  assign fifo_write_enable = |w_grant;
  assign fifo_write_dat    = w_grant[1] ? dat_b : dat_a;

  // one read in flight at a time; flush drains regardless of downstream
  assign fifo_read_enable = !rst && !fifo_empty && !r_pend &&
    ((r_state == ST_FLUSH) || !r_out_valid || out_ready);

  assign out_valid = r_out_valid;
  assign out_dat   = r_out_dat;

  always_comb begin
    w_state_nxt = r_state;
    flush_done  = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        if (flush)
          w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (!flush && fifo_empty && !r_pend) begin
          w_state_nxt = ST_RUN;
          flush_done  = !rst;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_pend      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_dat   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= fifo_read_enable;
      if ((r_state == ST_RUN) && !flush) begin
        if (r_pend) begin
          r_out_valid <= 1'b1;
          r_out_dat   <= fifo_read_dat;
        end else if (r_out_valid && out_ready) begin
          r_out_valid <= 1'b0;
        end
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/raster_fifo_arbiter.md
RASTER_FIFO_ARBITER -- requirements
Module: raster_fifo_arbiter

Interface
REQ-001 SHALL have parameter DAT_WID, default 24, giving the sample width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have ports req_a (input, 1) and dat_a (input, DAT_WID, signed): requester A's valid flag and data.
REQ-005 SHALL have port ack_a, output, 1 bit: A's datum is written this cycle.
REQ-006 SHALL have ports req_b, dat_b and ack_b, identical to the A ports, for requester B.
REQ-007 SHALL have fifo_write_enable (output, 1), fifo_write_dat (output, DAT_WID) and fifo_full (input, 1): the shared FIFO write side.
REQ-008 SHALL have fifo_read_enable (output, 1), fifo_read_dat (input, DAT_WID) and fifo_empty (input, 1): the shared FIFO read side; read data is valid one cycle after fifo_read_enable.
REQ-009 SHALL have out_valid (output, 1), out_dat (output, DAT_WID) and out_ready (input, 1): the downstream valid/ready stream.
REQ-010 SHALL have flush (input, 1 bit, level) and flush_done (output, 1-cycle pulse).

Function
REQ-011 Write handshake SHALL be valid/ready: a transfer occurs on a cycle with req_x=1 and ack_x=1; the requester changes dat_x/req_x only after a transfer.
REQ-012 ack_a and ack_b SHALL be combinational, at most one high per cycle, and both 0 when fifo_full=1 or state=FLUSH.
REQ-013 fifo_write_enable SHALL equal ack_a|ack_b; fifo_write_dat SHALL be the data of the acked requester (don't-care otherwise).
REQ-014 Arbitration SHALL be round-robin via a 1-bit priority register: sole requester wins; when both request, the prioritised one wins; after any transfer, priority moves to the other requester.
REQ-015 Read side SHALL keep a pending flag = fifo_read_enable of the previous cycle.
REQ-016 fifo_read_enable SHALL be asserted iff fifo_empty=0, pending=0, and (state=FLUSH or out_valid=0 or out_ready=1).
REQ-017 In RUN, when pending=1, out_dat SHALL load fifo_read_dat and out_valid SHALL go 1; otherwise out_valid SHALL clear on out_valid&out_ready.
REQ-018 Peak read throughput SHALL be one word per 2 cycles; no read SHALL be issued while pending, so the FIFO cannot underflow.
REQ-019 FSM states SHALL be RUN and FLUSH.
REQ-020 RUN->FLUSH SHALL occur when flush=1; entering FLUSH SHALL clear out_valid, discarding the held word.
REQ-021 In FLUSH, returned read data SHALL be discarded and out_valid SHALL stay 0.
REQ-022 FLUSH->RUN SHALL occur when flush=0, fifo_empty=1 and pending=0; flush_done SHALL pulse for exactly that transition cycle.
REQ-023 If flush stays high after the FIFO is drained, the block SHALL stay in FLUSH with no pulse until flush falls.
REQ-024 Simultaneous write and read in one cycle SHALL be allowed.

Reset
REQ-025 With rst=1 at a clock edge, the block SHALL enter RUN and clear pending, out_valid, flush_done and priority (A first); out_dat SHALL be 0.
REQ-026 While rst=1, ack_a, ack_b, fifo_write_enable and fifo_read_enable SHALL be 0.
REQ-027 Reset mid-transfer SHALL drop any pending read result without presenting it.

Structure
REQ-028 State encoding (RUN/FLUSH) and the default DAT_WID SHALL live in the shared raster package.
REQ-029 Arbitration SHALL be a sub-module, rr_arbiter2 (req[1:0] in, grant[1:0] out, advance in), with the read/flush logic in the parent.
REQ-030 The block SHALL be wired to ram_fifo; no FIFO storage SHALL be inside this block.

Verification
REQ-031 Both requesting continuously, fifo_full=0 -> acks alternate A,B,A,B starting with A after reset; 8 transfers give 4 each.
REQ-032 req_a=1 with fifo_full=1 for 3 cycles -> ack_a=0 throughout; ack_a=1 on the cycle fifo_full falls.
REQ-033 Write 0x000001..0x000004 with out_ready=1 -> out_dat stream is 1,2,3,4 in order, one word per 2 cycles, with fifo_read_enable never set while pending.
REQ-034 out_ready=0 with 3 words queued -> exactly one read is issued, out_valid holds with a stable out_dat, and there are no further reads until out_ready=1.
REQ-035 5 words queued, flush pulsed for 1 cycle -> out_valid stays 0, 5 reads are issued, and flush_done pulses once when fifo_empty=1 and pending=0; acks stay 0 meanwhile.
REQ-036 rst asserted the cycle after fifo_read_enable -> no out_valid the next cycle, and priority returns to A.
